// File: rtl/dmem_access_unit_if.sv
// Core-side memory-stage bus of the data-memory access unit.
// The master drives the request; the slave returns load data, stall and misalign.
interface dmem_access_unit_if;
    logic        req;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  mem_op;
    logic [31:0] rdata;
    logic        stall;
    logic        misalign;

    modport master (
        output req, addr, wdata, mem_op,
        input  rdata, stall, misalign
    );

    modport slave (
        input  req, addr, wdata, mem_op,
        output rdata, stall, misalign
    );
endinterface

// File: rtl/dmem_access_unit.sv
// Multi-cycle data-memory access controller: sized loads with extension, SW direct,
// SH/SB by read-modify-write on a single-port synchronous RAM, with misalignment trapping.
module dmem_access_unit #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    dmem_access_unit_if.slave core,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam logic [2:0] OpLw  = 3'd0;
    localparam logic [2:0] OpLh  = 3'd1;
    localparam logic [2:0] OpLhu = 3'd2;
    localparam logic [2:0] OpLb  = 3'd3;
    localparam logic [2:0] OpLbu = 3'd4;
    localparam logic [2:0] OpSw  = 3'd5;
    localparam logic [2:0] OpSh  = 3'd6;
    localparam logic [2:0] OpSb  = 3'd7;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StWait,
        StWr,
        StDone,
        StErr
    } state_e;

    state_e state_q, state_d;

    logic [ADDR_W+1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [2:0]        op_q;
    logic [31:0]       rdata_q;
    logic [31:0]       merge_q;

    logic              aligned;
    logic              accept;
    logic              op_is_load;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [31:0]       load_val;
    logic [31:0]       merged;
    logic              busy;

    // Upper byte-address bits lie outside the RAM and are ignored.
    logic unused_addr;
    assign unused_addr = ^core.addr[31:ADDR_W+2];

    always_comb begin
        aligned = 1'b1;
        unique case (core.mem_op)
            OpLw, OpSw:       aligned = (core.addr[1:0] == 2'b00);
            OpLh, OpLhu, OpSh: aligned = ~core.addr[0];
            default:          aligned = 1'b1;
        endcase
    end

    assign accept     = (state_q == StIdle) && core.req;
    assign op_is_load = (op_q <= OpLbu);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (core.req) begin
                    if (!aligned) begin
                        state_d = StErr;
                    end else if (core.mem_op == OpSw) begin
                        state_d = StWr;
                    end else begin
                        state_d = StRd;
                    end
                end
            end
            StRd:   state_d = StWait;
            StWait: state_d = op_is_load ? StDone : StWr;
            StWr:   state_d = StDone;
            StDone: state_d = StIdle;
            StErr:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Lane selection and extension of the word returned by the RAM.
    always_comb begin
        rd_byte = ram_rdata[{addr_q[1:0], 3'b000} +: 8];
        rd_half = addr_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
        unique case (op_q)
            OpLh:    load_val = {{16{rd_half[15]}}, rd_half};
            OpLhu:   load_val = {16'h0000, rd_half};
            OpLb:    load_val = {{24{rd_byte[7]}}, rd_byte};
            OpLbu:   load_val = {24'h000000, rd_byte};
            default: load_val = ram_rdata;
        endcase
    end

    // Sub-word store: overlay the low store-data bits onto the selected lane.
    always_comb begin
        merged = ram_rdata;
        if (op_q == OpSh) begin
            if (addr_q[1]) begin
                merged[31:16] = wdata_q[15:0];
            end else begin
                merged[15:0] = wdata_q[15:0];
            end
        end else if (op_q == OpSb) begin
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            op_q    <= OpLw;
        end else if (accept) begin
            addr_q  <= core.addr[ADDR_W+1:0];
            wdata_q <= core.wdata;
            op_q    <= core.mem_op;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= '0;
            merge_q <= '0;
        end else if (state_q == StWait) begin
            if (op_is_load) begin
                rdata_q <= load_val;
            end else begin
                merge_q <= merged;
            end
        end
    end

    // Outputs decoded from state only, so reset clears them at once.
    always_comb begin
        ram_en        = 1'b0;
        ram_we        = 1'b0;
        ram_addr      = '0;
        ram_wdata     = '0;
        core.misalign = 1'b0;
        busy          = 1'b1;
        case (state_q)
            StRd: begin
                ram_en   = 1'b1;
                ram_addr = addr_q[ADDR_W+1:2];
            end
            StWr: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = addr_q[ADDR_W+1:2];
                ram_wdata = (op_q == OpSw) ? wdata_q : merge_q;
            end
            StDone: busy = 1'b0;
            StErr: begin
                busy          = 1'b0;
                core.misalign = 1'b1;
            end
            default: ;
        endcase
        core.stall = rst & core.req & busy;
        core.rdata = rdata_q;
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench for dmem_access_unit: directed table, corner sequences and
// randomized operations checked against a word-array reference model.
module tb_dmem_access_unit;

    localparam int ADDR_W = 10;
    localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3, LBU = 3'd4;
    localparam logic [2:0] SW = 3'd5, SH = 3'd6, SB = 3'd7;

    logic clk = 1'b0;
    logic rst;
    logic ram_en, ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0] ram_wdata, ram_rdata;

    always #5 clk = ~clk;

    dmem_access_unit_if bus();

    dmem_access_unit #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .core      (bus),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    // Single-port synchronous RAM seen by the DUT.
    logic [31:0] mem [1024];
    int wr_total = 0;
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                mem[ram_addr] <= ram_wdata;
                wr_total <= wr_total + 1;
            end else begin
                ram_rdata <= mem[ram_addr];
            end
        end
    end

    // Reference model state.
    logic [31:0] ref_mem [1024];
    logic [31:0] ref_rdata;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Architectural effect of one access: updates model memory/load result and
    // returns expected stall cycles, RAM enables, RAM writes and misalign pulses.
    function automatic void ref_step(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] wd, output int es, output int een,
                                     output int ewe, output int emis);
        logic [9:0]  wi;
        logic [31:0] w, h, b;
        int bs, hs;
        bit ok;
        wi = a[11:2];
        w  = ref_mem[wi];
        bs = 8 * int'(a[1:0]);
        hs = 16 * int'(a[1]);
        if (op == LW || op == SW) ok = (a[1:0] == 2'b00);
        else if (op == LH || op == LHU || op == SH) ok = (a[0] == 1'b0);
        else ok = 1'b1;
        if (!ok) begin
            es = 1; een = 0; ewe = 0; emis = 1;
            return;
        end
        emis = 0;
        h = (w >> hs) & 32'h0000FFFF;
        b = (w >> bs) & 32'h000000FF;
        case (op)
            LW:  ref_rdata = w;
            LH:  ref_rdata = h[15] ? (h | 32'hFFFF0000) : h;
            LHU: ref_rdata = h;
            LB:  ref_rdata = b[7] ? (b | 32'hFFFFFF00) : b;
            LBU: ref_rdata = b;
            SW:  ref_mem[wi] = wd;
            SH:  ref_mem[wi] = (w & ~(32'h0000FFFF << hs)) | ((wd & 32'h0000FFFF) << hs);
            default: ref_mem[wi] = (w & ~(32'h000000FF << bs)) | ((wd & 32'h000000FF) << bs);
        endcase
        es  = (op <= LBU) ? 3 : (op == SW) ? 2 : 4;
        een = (op == SH || op == SB) ? 2 : 1;
        ewe = (op >= SW) ? 1 : 0;
    endfunction

    // Drive one request and observe it until stall drops (bounded).
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                          input bit keep, output int ns, output int nen, output int nwe,
                          output int nmis, output logic [31:0] ra);
        @(negedge clk);
        bus.req = 1'b1; bus.addr = a; bus.wdata = wd; bus.mem_op = op;
        #1;
        ns = 0; nen = 0; nwe = 0; nmis = 0; ra = '0;
        for (int c = 0; c < 20 && bus.stall; c++) begin
            ns++;
            if (ram_en) begin nen++; ra = 32'(ram_addr); end
            if (ram_we) nwe++;
            if (bus.misalign) nmis++;
            @(negedge clk); #1;
        end
        if (ram_en) nen++;
        if (ram_we) nwe++;
        if (bus.misalign) nmis++;
        if (!keep) bus.req = 1'b0;
    endtask

    task automatic check_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] wd, input bit keep, output int ns,
                            output int nmis);
        int es, een, ewe, emis, nen, nwe;
        logic [31:0] ra;
        ref_step(op, a, wd, es, een, ewe, emis);
        run_op(op, a, wd, keep, ns, nen, nwe, nmis, ra);
        chk({tag, ".stall"}, ns, es);
        chk({tag, ".ram_en"}, nen, een);
        chk({tag, ".ram_we"}, nwe, ewe);
        chk({tag, ".misalign"}, nmis, emis);
        chk({tag, ".rdata"}, bus.rdata, ref_rdata);
        chk({tag, ".mem"}, mem[a[11:2]], ref_mem[a[11:2]]);
        if (een > 0) chk({tag, ".ram_addr"}, ra, 32'(a[11:2]));
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_stall;
        logic        exp_mis;
    } vec_t;

    vec_t tbl [11];

    initial begin
        int ns, nmis, wr0;
        logic [2:0] op;
        logic [31:0] a, wd, keepw;

        tbl[0]  = '{SW,  32'h10, 32'hDEADBEEF, 32'h00000000, 2, 1'b0};
        tbl[1]  = '{LW,  32'h10, 32'h0,        32'hDEADBEEF, 3, 1'b0};
        tbl[2]  = '{SB,  32'h22, 32'h000000AA, 32'hDEADBEEF, 4, 1'b0};
        tbl[3]  = '{LB,  32'h22, 32'h0,        32'hFFFFFFAA, 3, 1'b0};
        tbl[4]  = '{LBU, 32'h22, 32'h0,        32'h000000AA, 3, 1'b0};
        tbl[5]  = '{LW,  32'h20, 32'h0,        32'h11AA3344, 3, 1'b0};
        tbl[6]  = '{LH,  32'h32, 32'h0,        32'hFFFF8001, 3, 1'b0};
        tbl[7]  = '{LHU, 32'h32, 32'h0,        32'h00008001, 3, 1'b0};
        tbl[8]  = '{LH,  32'h30, 32'h0,        32'h00007FFF, 3, 1'b0};
        tbl[9]  = '{LW,  32'h06, 32'h0,        32'h00007FFF, 1, 1'b1};
        tbl[10] = '{SH,  32'h03, 32'h00001234, 32'h00007FFF, 1, 1'b1};

        for (int i = 0; i < 1024; i++) begin
            keepw = $urandom;
            mem[i] <= keepw;
            ref_mem[i] = keepw;
        end
        mem[0] <= 32'h01234567;  ref_mem[0] = 32'h01234567;
        mem[1] <= 32'hCAFEF00D;  ref_mem[1] = 32'hCAFEF00D;
        mem[8] <= 32'h11223344;  ref_mem[8] = 32'h11223344;
        mem[12] <= 32'h80017FFF; ref_mem[12] = 32'h80017FFF;
        mem[16] <= 32'h00000000; ref_mem[16] = 32'h00000000;
        ref_rdata = '0;

        bus.req = 1'b0; bus.addr = '0; bus.wdata = '0; bus.mem_op = LW;
        rst = 1'b0;
        #3;
        chk("reset.rdata", bus.rdata, 32'h0);
        chk("reset.stall", {31'b0, bus.stall}, 32'h0);
        chk("reset.misalign", {31'b0, bus.misalign}, 32'h0);
        chk("reset.ram_en", {31'b0, ram_en}, 32'h0);
        chk("reset.ram_we", {31'b0, ram_we}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Directed table.
        for (int i = 0; i < 11; i++) begin
            check_op($sformatf("tbl%0d", i), tbl[i].op, tbl[i].addr, tbl[i].wdata, 1'b0,
                     ns, nmis);
            chk($sformatf("tbl%0d.exp_rdata", i), bus.rdata, tbl[i].exp_rdata);
            chk($sformatf("tbl%0d.exp_stall", i), ns, tbl[i].exp_stall);
            chk($sformatf("tbl%0d.exp_mis", i), nmis, {31'b0, tbl[i].exp_mis});
        end
        chk("tbl.word_sb", mem[8], 32'h11AA3344);
        chk("tbl.word_sw", mem[4], 32'hDEADBEEF);
        chk("tbl.word0", mem[0], 32'h01234567);
        chk("tbl.word1", mem[1], 32'hCAFEF00D);

        // Back-to-back SH then LH with req held high.
        wr0 = wr_total;
        check_op("b2b_sh", SH, 32'h42, 32'h5555BEEF, 1'b1, ns, nmis);
        check_op("b2b_lh", LH, 32'h42, 32'h0, 1'b0, ns, nmis);
        chk("b2b.rdata", bus.rdata, 32'hFFFFBEEF);
        chk("b2b.word", mem[16], 32'hBEEF0000);
        chk("b2b.writes", wr_total - wr0, 1);

        // Reset asserted while an SB sits in WAIT: no write, everything cleared.
        wr0 = wr_total;
        @(negedge clk);
        bus.req = 1'b1; bus.addr = 32'h50; bus.wdata = 32'h77; bus.mem_op = SB;
        @(negedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;
        bus.req = 1'b0;
        #1;
        chk("rstwait.rdata", bus.rdata, 32'h0);
        chk("rstwait.stall", {31'b0, bus.stall}, 32'h0);
        chk("rstwait.misalign", {31'b0, bus.misalign}, 32'h0);
        chk("rstwait.ram_en", {31'b0, ram_en}, 32'h0);
        chk("rstwait.ram_we", {31'b0, ram_we}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        ref_rdata = '0;
        chk("rstwait.writes", wr_total - wr0, 0);
        chk("rstwait.word", mem[20], ref_mem[20]);
        check_op("after_rst", LW, 32'h50, 32'h0, 1'b0, ns, nmis);

        // req dropped after acceptance: store still completes, stall follows req.
        wr0 = wr_total;
        @(negedge clk);
        bus.req = 1'b1; bus.addr = 32'h60; bus.wdata = 32'h12345678; bus.mem_op = SW;
        #1;
        chk("drop.stall_hi", {31'b0, bus.stall}, 32'h1);
        @(negedge clk);
        #1;
        bus.req = 1'b0;
        #1;
        chk("drop.stall_lo", {31'b0, bus.stall}, 32'h0);
        chk("drop.ram_we", {31'b0, ram_we}, 32'h1);
        repeat (2) @(negedge clk);
        ref_mem[24] = 32'h12345678;
        chk("drop.word", mem[24], 32'h12345678);
        chk("drop.writes", wr_total - wr0, 1);

        // Randomized operations against the reference model.
        for (int i = 0; i < 250; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = 32'($urandom_range(0, 255));
            wd = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (op == LW || op == SW) a[1:0] = 2'b00;
                else if (op == LH || op == LHU || op == SH) a[0] = 1'b0;
            end
            if ($urandom_range(0, 7) == 0) a[31:12] = 20'($urandom);
            check_op($sformatf("rnd%0d", i), op, a, wd, 1'($urandom_range(0, 1)), ns, nmis);
            if ($urandom_range(0, 3) == 0) begin
                bus.req = 1'b0;
                @(negedge clk);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
